// File: rtl/f_pc_npc_pkg.sv
// Shared fetch-stage constants: next-PC select encodings and the instruction
// memory address map, also consumed by CP0 and the D-stage control unit.
package f_pc_npc_pkg;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_B   = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_END    = 32'h0000_6ffc;

endpackage

// File: rtl/f_npc_calc.sv
// Combinational next-PC target mux for branch, jump, jump-register and
// sequential fetch. Exception/eret redirects are handled by the caller.
module f_npc_calc
    import f_pc_npc_pkg::*;
(
    input  logic [2:0]  op,
    input  logic        cmp,
    input  logic [31:0] f_pc,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_imm26,
    input  logic [31:0] d_rs_data,
    output logic [31:0] npc
);

    logic [31:0] pc4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Targets are relative to D_PC so the delay-slot instruction always runs.
    assign pc4           = f_pc + 32'd4;
    assign branch_target = d_pc + 32'd4 + {{14{d_imm26[15]}}, d_imm26[15:0], 2'b00};
    assign jump_target   = {d_pc[31:28], d_imm26, 2'b00};

    always_comb begin
        npc = pc4;
        case (op)
            NPC_B:   npc = cmp ? branch_target : pc4;
            NPC_J:   npc = jump_target;
            NPC_JR:  npc = d_rs_data;
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/f_pc_npc.sv
// F-stage PC register with redirect priority (reset > req > stall > eret >
// D-stage target), fetch address error detection and delay-slot flag.
module f_pc_npc
    import f_pc_npc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] EPC,
    input  logic [2:0]  CU_NPC_op,
    input  logic        D_CMP_out,
    input  logic [31:0] D_PC,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_Data,
    output logic [31:0] F_PC,
    output logic        F_ExcAdEL,
    output logic        F_BD
);

    logic [31:0] pc;
    logic [31:0] npc_target;

    f_npc_calc u_calc (
        .op        (CU_NPC_op),
        .cmp       (D_CMP_out),
        .f_pc      (pc),
        .d_pc      (D_PC),
        .d_imm26   (D_imm26),
        .d_rs_data (D_rs_Data),
        .npc       (npc_target)
    );

    // Exception entry must not be lost to a hazard freeze, so req beats stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
        end else if (req) begin
            pc <= EXC_ENTRY;
        end else if (!stall) begin
            pc <= eret ? EPC : npc_target;
        end
    end

    assign F_PC      = pc;
    assign F_ExcAdEL = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_END);
    // Raw decode of the op: a not-taken branch still marks its slot.
    assign F_BD      = !reset && (CU_NPC_op != NPC_PC4);

endmodule

// File: tb/tb_f_pc_npc.sv
// Bench for f_pc_npc: directed literal scenarios followed by random traffic,
// all checked against a behavioural next-PC model every cycle.
module tb_f_pc_npc;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] EPC;
    logic [2:0]  CU_NPC_op;
    logic        D_CMP_out;
    logic [31:0] D_PC;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_Data;
    logic [31:0] F_PC;
    logic        F_ExcAdEL;
    logic        F_BD;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mpc = 32'h0;
    logic        mvalid = 1'b0;

    f_pc_npc dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .eret      (eret),
        .EPC       (EPC),
        .CU_NPC_op (CU_NPC_op),
        .D_CMP_out (D_CMP_out),
        .D_PC      (D_PC),
        .D_imm26   (D_imm26),
        .D_rs_Data (D_rs_Data),
        .F_PC      (F_PC),
        .F_ExcAdEL (F_ExcAdEL),
        .F_BD      (F_BD)
    );

    always #5 clk = ~clk;

    // Reference: what the PC must become after this edge, from the rule list.
    function automatic logic [31:0] model_next(input logic [31:0] cur);
        int off;
        logic signed [15:0] imm;
        imm = D_imm26[15:0];
        off = int'(imm) * 4;
        if (reset)  return 32'h0000_3000;
        if (req)    return 32'h0000_4180;
        if (stall)  return cur;
        if (eret)   return EPC;
        case (CU_NPC_op)
            3'd1:    return D_CMP_out ? (D_PC + 32'd4 + 32'(off)) : (cur + 32'd4);
            3'd2:    return {D_PC[31:28], D_imm26, 2'b00};
            3'd3:    return D_rs_Data;
            default: return cur + 32'd4;
        endcase
    endfunction

    function automatic logic model_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
    endfunction

    always @(posedge clk) begin
        if (reset || mvalid) exp_q.push_back(model_next(mpc));
        mpc <= model_next(mpc);
        if (reset) mvalid <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model_pc", F_PC, e);
            check("model_adel", {31'b0, F_ExcAdEL}, {31'b0, model_adel(e)});
            check("model_bd", {31'b0, F_BD}, {31'b0, (!reset && CU_NPC_op != 3'd0)});
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] op, input logic cmp, input logic [31:0] dpc,
                          input logic [25:0] imm, input logic [31:0] rs);
        CU_NPC_op = op;
        D_CMP_out = cmp;
        D_PC      = dpc;
        D_imm26   = imm;
        D_rs_Data = rs;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0; eret = 1'b0; EPC = 32'h0;
        set_in(3'd2, 1'b0, 32'h0, 26'h0, 32'h0);
        edge_step();
        edge_step();
        check("reset_pc", F_PC, 32'h3000);
        check("reset_bd", {31'b0, F_BD}, 32'h0);
        reset = 1'b0;
        set_in(3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
        #1 check("reset_adel", {31'b0, F_ExcAdEL}, 32'h0);
        edge_step(); check("seq_3004", F_PC, 32'h3004);
        edge_step(); check("seq_3008", F_PC, 32'h3008);

        // Branch taken backwards, then not taken.
        set_in(3'd1, 1'b1, 32'h3004, 26'h000FFFE, 32'h0);
        #1 check("branch_bd", {31'b0, F_BD}, 32'h1);
        edge_step(); check("branch_taken", F_PC, 32'h3000);
        set_in(3'd1, 1'b0, 32'h3004, 26'h000FFFE, 32'h0);
        #1 check("branch_nt_bd", {31'b0, F_BD}, 32'h1);
        edge_step(); check("branch_not_taken", F_PC, 32'h3004);

        set_in(3'd2, 1'b0, 32'h3010, 26'h0000C10, 32'h0);
        edge_step(); check("jump", F_PC, 32'h3040);
        set_in(3'd3, 1'b0, 32'h0, 26'h0, 32'h0000_5002);
        edge_step(); check("jr_unaligned", F_PC, 32'h5002);
        check("jr_unaligned_adel", {31'b0, F_ExcAdEL}, 32'h1);
        set_in(3'd3, 1'b0, 32'h0, 26'h0, 32'h0000_7000);
        edge_step(); check("jr_high", F_PC, 32'h7000);
        check("jr_high_adel", {31'b0, F_ExcAdEL}, 32'h1);
        set_in(3'd3, 1'b0, 32'h0, 26'h0, 32'h0000_6ffc);
        edge_step(); check("jr_top_legal_adel", {31'b0, F_ExcAdEL}, 32'h0);

        // Stall holds the PC; the branch resolves on the release edge.
        set_in(3'd3, 1'b0, 32'h0, 26'h0, 32'h0000_3008);
        edge_step(); check("stall_setup", F_PC, 32'h3008);
        stall = 1'b1;
        set_in(3'd1, 1'b1, 32'h3004, 26'h000FFFE, 32'h0);
        for (int i = 0; i < 3; i++) begin
            edge_step(); check("stall_hold", F_PC, 32'h3008);
        end
        stall = 1'b0;
        edge_step(); check("stall_release", F_PC, 32'h3000);

        // Exception entry and return.
        set_in(3'd0, 1'b0, 32'h0, 26'h0, 32'h0);
        stall = 1'b1; req = 1'b1;
        edge_step(); check("req_in_stall", F_PC, 32'h4180);
        stall = 1'b0; req = 1'b0; eret = 1'b1; EPC = 32'h0000_3020;
        edge_step(); check("eret", F_PC, 32'h3020);
        req = 1'b1;
        edge_step(); check("req_beats_eret", F_PC, 32'h4180);
        req = 1'b0; eret = 1'b0;

        // Reset while a jump is pending.
        set_in(3'd2, 1'b0, 32'h3010, 26'h0000C10, 32'h0);
        reset = 1'b1;
        edge_step(); check("reset_mid_pc", F_PC, 32'h3000);
        check("reset_mid_bd", {31'b0, F_BD}, 32'h0);
        reset = 1'b0;
        set_in(3'd0, 1'b0, 32'h0, 26'h0, 32'h0);

        // Random traffic, checked by the per-cycle model compare.
        for (int i = 0; i < 400; i++) begin
            edge_step();
            reset     = ($urandom_range(0, 99) < 2);
            req       = ($urandom_range(0, 99) < 5);
            stall     = ($urandom_range(0, 99) < 20);
            eret      = ($urandom_range(0, 99) < 8);
            EPC       = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 16'h0fff)) * 4);
            CU_NPC_op = 3'($urandom_range(0, 7));
            D_CMP_out = 1'($urandom);
            D_PC      = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 16'h0fff)) * 4);
            D_imm26   = 26'($urandom);
            D_rs_Data = ($urandom_range(0, 1) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 16'h0fff)) * 4);
        end
        reset = 1'b0; req = 1'b0; stall = 1'b0; eret = 1'b0;
        edge_step();
        edge_step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
